// File: rtl/moving_average_filter.sv
// N-tap boxcar average over a signed sample stream, using a running sum and a circular delay line.
// Define MOVING_AVERAGE_ROUND_EN to round half toward +inf; the default build floors.
module moving_average_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_ce,
  input  logic                         i_clear,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce,
  output logic                         o_full
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int AW   = DATA_WIDTH + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] TAPS_F = (LOG2_TAPS+1)'(TAPS);

  logic signed [DATA_WIDTH-1:0] dly_q [TAPS];
  logic        [LOG2_TAPS-1:0]  wr_ptr_q;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic        [LOG2_TAPS:0]    fill_q, fill_d;
  logic signed [DATA_WIDTH-1:0] data_q, avg_d;
  logic                         ce_q, full_q;
  logic signed [AW-1:0]         sx_in, sx_old;

  assign sx_in  = {{LOG2_TAPS{data_in[DATA_WIDTH-1]}}, data_in};
  assign sx_old = {{LOG2_TAPS{dly_q[wr_ptr_q][DATA_WIDTH-1]}}, dly_q[wr_ptr_q]};

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_TAPS-1);
  logic signed [AW:0] rnd_w;
  logic               rnd_unused;
  assign rnd_unused = ^{rnd_w[AW], rnd_w[LOG2_TAPS-1:0]};
`endif

  always_comb begin
    // oldest sample leaves the sum in the same cycle its slot is overwritten
    acc_d  = acc_q + sx_in - sx_old;
    fill_d = (fill_q == TAPS_F) ? fill_q : fill_q + 1'b1;
`ifdef MOVING_AVERAGE_ROUND_EN
    rnd_w  = {acc_d[AW-1], acc_d} + HALF;
    avg_d  = rnd_w[LOG2_TAPS +: DATA_WIDTH];
`else
    avg_d  = acc_d[LOG2_TAPS +: DATA_WIDTH];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) dly_q[i] <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      ce_q     <= 1'b0;
      full_q   <= 1'b0;
    end else if (i_clear) begin
      for (int i = 0; i < TAPS; i++) dly_q[i] <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      ce_q     <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      ce_q <= i_ce;
      if (i_ce) begin
        dly_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        acc_q           <= acc_d;
        data_q          <= avg_d;
        fill_q          <= fill_d;
        full_q          <= (fill_d == TAPS_F);
      end
    end
  end

  assign data_out = data_q;
  assign o_ce     = ce_q;
  assign o_full   = full_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench: a 2-tap and a 4-tap instance, directed vectors with hand-computed averages.
module tb_moving_average_filter;
`ifdef MOVING_AVERAGE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk, reset_n;
  logic ce_a, clr_a, ce_b, clr_b;
  logic signed [7:0] din_a, din_b, data_out_a, data_out_b;
  logic o_ce_a, o_full_a, o_ce_b, o_full_b;

  typedef struct { int d; bit f; } exp_t;
  exp_t qa[$], qb[$];
  int tests = 0, fails = 0;

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .i_ce(ce_a), .i_clear(clr_a), .data_in(din_a),
    .data_out(data_out_a), .o_ce(o_ce_a), .o_full(o_full_a));

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2)) u_b (
    .clk(clk), .reset_n(reset_n), .i_ce(ce_b), .i_clear(clr_b), .data_in(din_b),
    .data_out(data_out_b), .o_ce(o_ce_b), .o_full(o_full_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic step_a(input bit ce, input bit clr, input int d, input bit push, input int ed, input bit ef);
    exp_t e;
    ce_a = ce; clr_a = clr; din_a = 8'(d);
    if (push) begin e.d = ed; e.f = ef; qa.push_back(e); end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input bit ce, input bit clr, input int d, input bit push, input int ed, input bit ef);
    exp_t e;
    ce_b = ce; clr_b = clr; din_b = 8'(d);
    if (push) begin e.d = ed; e.f = ef; qb.push_back(e); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ce_a = 0; clr_a = 0; din_a = '0;
    ce_b = 0; clr_b = 0; din_b = '0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n && o_ce_a) begin
          if (qa.size() == 0) begin
            tests++; fails++;
            $display("FAIL monA_extra: got o_ce with data %0d, expected no output", data_out_a);
          end else begin
            e = qa.pop_front();
            chk("monA_data", int'(data_out_a), e.d);
            chk("monA_full", int'(o_full_a), int'(e.f));
          end
        end
        if (reset_n && o_ce_b) begin
          if (qb.size() == 0) begin
            tests++; fails++;
            $display("FAIL monB_extra: got o_ce with data %0d, expected no output", data_out_b);
          end else begin
            e = qb.pop_front();
            chk("monB_data", int'(data_out_b), e.d);
            chk("monB_full", int'(o_full_b), int'(e.f));
          end
        end
      end
    join_none

    #12;
    chk("rst_data_a", int'(data_out_a), 0);
    chk("rst_oce_a",  int'(o_ce_a), 0);
    chk("rst_full_a", int'(o_full_a), 0);
    chk("rst_data_b", int'(data_out_b), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // 2 taps, continuous strobe
    step_a(1, 0,  10, 1, 5, 0);
    step_a(1, 0, -20, 1, -5, 1);
    step_a(1, 0,  30, 1, 5, 1);
    step_a(1, 0, -40, 1, -5, 1);
    step_a(1, 0, 127, 1, RND ? 44 : 43, 1);
    step_a(1, 0, -60, 1, RND ? 34 : 33, 1);
    step_a(0, 0, 0, 0, 0, 0);

    // gapped strobe after a clear
    step_a(0, 1, 0, 0, 0, 0);
    chk("clr_full_a", int'(o_full_a), 0);
    step_a(1, 0, 8, 1, 4, 0);
    step_a(0, 0, 0, 0, 0, 0);
    chk("gap1_data", int'(data_out_a), 4);
    chk("gap1_oce",  int'(o_ce_a), 0);
    step_a(0, 0, 0, 0, 0, 0);
    chk("gap2_data", int'(data_out_a), 4);
    chk("gap2_oce",  int'(o_ce_a), 0);
    step_a(1, 0, 8, 1, 8, 1);

    // clear wins over a simultaneous sample
    step_a(1, 0, 20, 1, 14, 1);
    step_a(1, 1, 99, 0, 0, 0);
    chk("clrce_oce",  int'(o_ce_a), 0);
    chk("clrce_full", int'(o_full_a), 0);
    chk("clrce_data", int'(data_out_a), 0);
    step_a(1, 0, 40, 1, 20, 0);
    step_a(1, 0,  2, 1, 21, 1);
    step_a(1, 0, 50, 1, 26, 1);

    // asynchronous reset between edges
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst_data", int'(data_out_a), 0);
    chk("arst_oce",  int'(o_ce_a), 0);
    chk("arst_full", int'(o_full_a), 0);
    ce_a = 1'b0;
    #1 reset_n = 1'b1;
    step_a(1, 0, -6, 1, -3, 0);
    step_a(0, 0, 0, 0, 0, 0);

    // 4 taps
    step_b(1, 0,  10, 1, RND ? 3 : 2, 0);
    step_b(1, 0, -20, 1, RND ? -2 : -3, 0);
    step_b(1, 0,  30, 1, 5, 0);
    step_b(1, 0, -40, 1, -5, 1);
    step_b(0, 1, 0, 0, 0, 0);
    chk("clr_full_b", int'(o_full_b), 0);
    for (int i = 0; i < 8; i++)
      step_b(1, 0, 127, 1, (i == 0) ? (RND ? 32 : 31) : (i == 1) ? (RND ? 64 : 63) :
                           (i == 2) ? 95 : 127, i >= 3);
    for (int i = 0; i < 8; i++)
      step_b(1, 0, -128, 1, (i == 0) ? 63 : (i == 1) ? (RND ? 0 : -1) :
                            (i == 2) ? (RND ? -64 : -65) : -128, 1'b1);
    step_b(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("drainA", qa.size(), 0);
    chk("drainB", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
